// File: rtl/sigdiv_pkg.sv
// rtl/sigdiv_pkg.sv - sizes, iteration count and FSM states for the significand divider (SIGDIV_RADIX4_EN)
package sigdiv_pkg;

  localparam int NSIG = 10;
  localparam int QW   = NSIG + 4;

`ifdef SIGDIV_RADIX4_EN
  localparam int SPC  = 2;
`else
  localparam int SPC  = 1;
`endif

  localparam int ITER = QW / SPC;
  localparam int CW   = $clog2(ITER + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sigdiv_if.sv
// rtl/sigdiv_if.sv - operand/result handshake between fp_div and the significand divider
interface sigdiv_if;
  import sigdiv_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [NSIG:0]   a;
  logic [NSIG:0]   b;
  logic            out_valid;
  logic            out_ready;
  logic [QW-1:0]   q;
  logic            sticky;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, q, sticky
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, q, sticky
  );

endinterface

// File: rtl/sigdiv_step.sv
// rtl/sigdiv_step.sv - one combinational restoring division step
module sigdiv_step
  import sigdiv_pkg::*;
(
  input  logic [NSIG+1:0] r,
  input  logic [NSIG:0]   d,
  output logic [NSIG+1:0] r_next,
  output logic            q_bit
);

  logic [NSIG+1:0] rem;

  // r < 2d is invariant, so the doubled partial remainder never loses a bit
  always_comb begin
    q_bit  = (r >= {1'b0, d});
    rem    = q_bit ? (r - {1'b0, d}) : r;
    r_next = rem << 1;
  end

endmodule

// File: rtl/sigdiv_10.sv
// rtl/sigdiv_10.sv - iterative restoring significand divider, 1 or 2 (SIGDIV_RADIX4_EN) quotient bits per cycle
module sigdiv_10
  import sigdiv_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  sigdiv_if.slave  bus
);

  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  state_t            state;
  state_t            state_n;
  logic [CW-1:0]     cnt;
  logic [NSIG+1:0]   r;
  logic [NSIG+1:0]   r_step;
  logic [NSIG:0]     d;
  logic [QW-SPC-1:0] qacc;
  logic [QW-1:0]     q_next;
  logic [QW-1:0]     q_r;
  logic              sticky_r;
  logic              last;

  assign last = (cnt == LAST);

`ifdef SIGDIV_RADIX4_EN
  logic [NSIG+1:0] r_mid;
  logic            q_bit_hi;
  logic            q_bit_lo;

  if ((QW % 2) != 0) begin : g_odd_width
    $error("sigdiv_10: two steps per cycle need an even quotient width");
  end

  sigdiv_step u_step_hi (.r(r),     .d(d), .r_next(r_mid),  .q_bit(q_bit_hi));
  sigdiv_step u_step_lo (.r(r_mid), .d(d), .r_next(r_step), .q_bit(q_bit_lo));
  assign q_next = {qacc, q_bit_hi, q_bit_lo};
`else
  logic q_bit0;

  sigdiv_step u_step (.r(r), .d(d), .r_next(r_step), .q_bit(q_bit0));
  assign q_next = {qacc, q_bit0};
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.in_valid) state_n = CALC;
      CALC:    if (last)         state_n = DONE;
      DONE:    if (bus.out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      r        <= '0;
      d        <= '0;
      qacc     <= '0;
      q_r      <= '0;
      sticky_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            r    <= {1'b0, bus.a};
            d    <= bus.b;
            qacc <= '0;
            cnt  <= '0;
          end
        end
        CALC: begin
          r    <= r_step;
          qacc <= q_next[QW-SPC-1:0];
          cnt  <= cnt + 1'b1;
          // doubling is lossless, so a zero doubled remainder means an exact quotient
          if (last) begin
            q_r      <= q_next;
            sticky_r <= (r_step != '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.q         = q_r;
  assign bus.sticky    = sticky_r;

endmodule

// File: doc/sigdiv_10.md
# sigdiv_10

Sequential significand divider for IEEE 754 binary16 division, the counterpart of the combinational significand multiplier in the floating-point datapath. Takes two normalized 11-bit significands (hidden bit set), produces a 14-bit truncated quotient plus sticky bit by iterative restoring division. The parent fp_div module feeds it through a valid/ready handshake and uses q/sticky for rounding.

## Interface
- NSIG, 10, stored significand bits; operands are NSIG+1 bits, quotient NSIG+4 bits.
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  operands present.
- in_ready  out  1  block idle, can accept.
- a  in  NSIG+1  dividend significand; a[NSIG] must be 1.
- b  in  NSIG+1  divisor significand; b[NSIG] must be 1.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- q  out  NSIG+4  floor(a * 2^(NSIG+3) / b); q[NSIG+3] is integer bit.
- sticky  out  1  final remainder nonzero.

## Operation
- States: IDLE, CALC, DONE. in_ready = (state == IDLE); out_valid = (state == DONE).
- IDLE: on in_valid && in_ready, load R <= a (NSIG+2 bits), B <= b, Q <= 0, iteration counter <= 0, go to CALC.
- CALC, per iteration: bit = (R >= B); R <= 2*(bit ? R - B : R); Q <= {Q[NSIG+2:0], bit}. R < 2B always holds, so R never exceeds NSIG+2 bits.
- After last iteration: q <= Q, sticky <= (remainder before final doubling != 0), go to DONE.
- DONE: q, sticky held stable while out_ready low; on out_ready edge go to IDLE.
- in_valid ignored outside IDLE; no overlap of operations.
- a/b in [0.5, 2); q[NSIG+3]=1 means quotient >= 1; normalization shift left to parent.
- Operands with hidden bit clear: result unspecified, but FSM still completes and returns to IDLE.

## Timing
- Reset: state IDLE, in_ready 1, out_valid 0, q 0, sticky 0, counter 0, R/B/Q 0.
- Accept at edge t0; iterations on edges t1..tN; out_valid 1 from tN, N = NSIG+4 = 14 (radix-2).
- out_ready high at tN: handshake completes at edge tN+1, in_ready 1 from tN+1, next accept earliest tN+2. Back-to-back interval N+2 cycles.
- rst high at any edge, including mid-CALC or DONE: reset values apply after that edge, partial result discarded, no out_valid.
- Outputs registered; no combinational path from in_valid/a/b to outputs. out_ready -> in_ready is one registered state transition.

## Configuration
- SIGDIV_RADIX4_EN defined: two restoring steps chained per cycle, N = (NSIG+4)/2 = 7 (NSIG+4 must be even; elaborate-time error otherwise). Undefined: one step per cycle, N = 14.
- q and sticky bit-identical in both builds; only latency and interval change.

## Structure
- Package sigdiv_pkg: state enum (IDLE/CALC/DONE), NSIG default, ITER constant (radix dependent), counter width $clog2(ITER+1).
- Sub-module sigdiv_step: combinational single restoring step (R, B -> R_next, bit); instantiated once, or twice in series under SIGDIV_RADIX4_EN.
- Top: FSM, counter, R/B/Q registers, output registers.

## Test plan
- a=0x400, b=0x400 -> q=0x2000, sticky 0, out_valid at t14 (t7 radix-4).
- a=0x7FF, b=0x400 -> q=0x3FF8, sticky 0.
- a=0x400, b=0x7FF -> q=0x1002, sticky 1; a=0x600, b=0x500 -> q=0x2666, sticky 1.
- out_ready low 5 cycles after out_valid, in_valid pulsed meanwhile -> q/sticky stable, in_ready 0, no new op; release -> IDLE next edge.
- rst at iteration 5 of CALC -> out_valid 0, in_ready 1 next cycle; following a=0x600,b=0x500 yields q=0x2666.
- 1000 random normalized pairs, out_ready random, vs. reference model floor(a*8192/b) and remainder != 0 -> exact match, interval N+2 when out_ready held 1.
